// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-to-one memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_BUSY_IFU = 2'd1,
      ARB_BUSY_LSU = 2'd2
   } arb_state_t;

   localparam logic ARB_ID_IFU = 1'b0;
   localparam logic ARB_ID_LSU = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and downstream memory handshakes around the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int MASK_W = DATA_W / 8;

   logic              ifu_reqValid;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_respValid;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_reqValid;
   logic [ADDR_W-1:0] lsu_addr;
   logic [1:0]        lsu_size;
   logic              lsu_wen;
   logic [DATA_W-1:0] lsu_wdata;
   logic [MASK_W-1:0] lsu_wmask;
   logic              lsu_respValid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              mem_reqValid;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_size;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic              mem_respValid;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   // Arbiter side: accepts CPU requests, issues memory requests.
   modport slave (
      input  ifu_reqValid, ifu_addr,
      input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_respValid, mem_rdata,
      output ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
      output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
      output busy
   );

   modport master (
      output ifu_reqValid, ifu_addr,
      output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
      output mem_respValid, mem_rdata,
      input  ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
      input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
      input  busy
   );

endinterface

// File: rtl/mem_arb_slot.sv
// One pending-request register: captures a packed request, holds it until granted.
module mem_arb_slot #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         capture,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
      end
   end

   // Payload is qualified by valid, so it needs no reset.
   always_ff @(posedge clock) begin
      if (capture) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter merging instruction fetch and load/store onto one memory bus,
// one transaction in flight, round-robin on ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam int MASK_W = DATA_W / 8;
   localparam int REQ_W  = ADDR_W + 2 + 1 + DATA_W + MASK_W;

   arb_state_t       state;
   logic             last_grant;
   logic [REQ_W-1:0] ifu_req, lsu_req, ifu_slot, lsu_slot, win_req;
   logic             ifu_pend, lsu_pend;
   logic             idle, ifu_cand, lsu_cand, grant, win;
   logic             ifu_clear, lsu_clear, ifu_capture, lsu_capture;

   // Fetches are always word reads with no write data.
   assign ifu_req = {bus.ifu_addr, SIZE_WORD, 1'b0, {DATA_W{1'b0}}, {MASK_W{1'b0}}};
   assign lsu_req = {bus.lsu_addr, bus.lsu_size, bus.lsu_wen, bus.lsu_wdata, bus.lsu_wmask};

   mem_arb_slot #(.W(REQ_W)) u_ifu_slot (
      .clock   (clock),
      .reset   (reset),
      .capture (ifu_capture),
      .clear   (ifu_clear),
      .din     (ifu_req),
      .valid   (ifu_pend),
      .dout    (ifu_slot)
   );

   mem_arb_slot #(.W(REQ_W)) u_lsu_slot (
      .clock   (clock),
      .reset   (reset),
      .capture (lsu_capture),
      .clear   (lsu_clear),
      .din     (lsu_req),
      .valid   (lsu_pend),
      .dout    (lsu_slot)
   );

   always_comb begin
      idle     = (state == ARB_IDLE);
      ifu_cand = idle && (ifu_pend || bus.ifu_reqValid);
      lsu_cand = idle && (lsu_pend || bus.lsu_reqValid);
      grant    = ifu_cand || lsu_cand;
      if (ifu_cand && lsu_cand) begin
         win = (last_grant == ARB_ID_IFU) ? ARB_ID_LSU : ARB_ID_IFU;
      end else begin
         win = lsu_cand ? ARB_ID_LSU : ARB_ID_IFU;
      end
      if (win == ARB_ID_LSU) begin
         win_req = lsu_pend ? lsu_slot : lsu_req;
      end else begin
         win_req = ifu_pend ? ifu_slot : ifu_req;
      end
      ifu_clear = grant && (win == ARB_ID_IFU);
      lsu_clear = grant && (win == ARB_ID_LSU);
      // A live request that is granted straight from the pins bypasses its slot;
      // one arriving while pending or in flight is dropped.
      ifu_capture = bus.ifu_reqValid && !ifu_pend && (state != ARB_BUSY_IFU) && !ifu_clear;
      lsu_capture = bus.lsu_reqValid && !lsu_pend && (state != ARB_BUSY_LSU) && !lsu_clear;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= ARB_IDLE;
         last_grant        <= ARB_ID_LSU;
         bus.mem_reqValid  <= 1'b0;
         bus.mem_addr      <= '0;
         bus.mem_size      <= '0;
         bus.mem_wen       <= 1'b0;
         bus.mem_wdata     <= '0;
         bus.mem_wmask     <= '0;
         bus.ifu_respValid <= 1'b0;
         bus.ifu_rdata     <= '0;
         bus.lsu_respValid <= 1'b0;
         bus.lsu_rdata     <= '0;
         bus.busy          <= 1'b0;
      end else begin
         bus.mem_reqValid  <= 1'b0;
         bus.ifu_respValid <= 1'b0;
         bus.lsu_respValid <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant) begin
                  bus.mem_reqValid <= 1'b1;
                  {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} <= win_req;
                  last_grant       <= win;
                  bus.busy         <= 1'b1;
                  state            <= (win == ARB_ID_LSU) ? ARB_BUSY_LSU : ARB_BUSY_IFU;
               end
            end
            ARB_BUSY_IFU: begin
               if (bus.mem_respValid) begin
                  bus.ifu_rdata     <= bus.mem_rdata;
                  bus.ifu_respValid <= 1'b1;
                  bus.busy          <= 1'b0;
                  state             <= ARB_IDLE;
               end
            end
            ARB_BUSY_LSU: begin
               if (bus.mem_respValid) begin
                  bus.lsu_rdata     <= bus.mem_rdata;
                  bus.lsu_respValid <= 1'b1;
                  bus.busy          <= 1'b0;
                  state             <= ARB_IDLE;
               end
            end
            default: begin
               state    <= ARB_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and responses are queued
// as stimulus is driven and compared as the arbiter produces them.
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mreq_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mem_lat = 1;
   int last_mresp_cyc = -100;
   int last_iresp_cyc = -100;
   int last_lresp_cyc = -100;
   int n_resp = 0;
   int mreq_cyc_q[$];
   mreq_t mem_q[$];
   logic [31:0] ifu_q[$];
   logic [31:0] lsu_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return ~a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_ifu(input logic [31:0] a);
      mreq_t e;
      bus.ifu_reqValid = 1'b1;
      bus.ifu_addr     = a;
      e = '{addr: a, size: 2'd2, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
      mem_q.push_back(e);
      ifu_q.push_back(mem_data(a));
   endtask

   task automatic set_lsu(input logic [31:0] a, input logic [1:0] sz, input logic wen,
                          input logic [31:0] wd, input logic [3:0] wm);
      mreq_t e;
      bus.lsu_reqValid = 1'b1;
      bus.lsu_addr     = a;
      bus.lsu_size     = sz;
      bus.lsu_wen      = wen;
      bus.lsu_wdata    = wd;
      bus.lsu_wmask    = wm;
      e = '{addr: a, size: sz, wen: wen, wdata: wd, wmask: wm};
      mem_q.push_back(e);
      lsu_q.push_back(mem_data(a));
   endtask

   task automatic clr_req();
      bus.ifu_reqValid = 1'b0;
      bus.lsu_reqValid = 1'b0;
      bus.lsu_wdata    = $urandom;
      bus.lsu_addr     = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((mem_q.size() != 0 || ifu_q.size() != 0 || lsu_q.size() != 0 || bus.busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("idle_wait_ok", n < 200, 1);
   endtask

   // Memory model: answers each request mem_lat cycles later (0 = same cycle).
   initial begin
      logic [31:0] d;
      bus.mem_respValid = 1'b0;
      bus.mem_rdata     = '0;
      forever begin
         @(negedge clock);
         if (!reset && bus.mem_reqValid) begin
            d = mem_data(bus.mem_addr);
            repeat (mem_lat) @(negedge clock);
            bus.mem_rdata     = d;
            bus.mem_respValid = 1'b1;
            last_mresp_cyc    = cyc;
            @(negedge clock);
            bus.mem_respValid = 1'b0;
            bus.mem_rdata     = $urandom;
         end
      end
   end

   // Output monitor against the scoreboard queues.
   always @(negedge clock) begin
      mreq_t e;
      logic [31:0] r;
      if (!reset) begin
         if (bus.mem_reqValid) begin
            mreq_cyc_q.push_back(cyc);
            check("mem_req_expected", mem_q.size() != 0, 1);
            if (mem_q.size() != 0) begin
               e = mem_q.pop_front();
               check("mem_addr", bus.mem_addr, e.addr);
               check("mem_size", bus.mem_size, e.size);
               check("mem_wen", bus.mem_wen, e.wen);
               check("mem_wdata", bus.mem_wdata, e.wdata);
               check("mem_wmask", bus.mem_wmask, e.wmask);
            end
         end
         if (bus.ifu_respValid) begin
            n_resp++;
            last_iresp_cyc = cyc;
            check("ifu_resp_expected", ifu_q.size() != 0, 1);
            check("ifu_resp_lat", cyc, last_mresp_cyc + 1);
            if (ifu_q.size() != 0) begin
               r = ifu_q.pop_front();
               check("ifu_rdata", bus.ifu_rdata, r);
            end
         end
         if (bus.lsu_respValid) begin
            n_resp++;
            last_lresp_cyc = cyc;
            check("lsu_resp_expected", lsu_q.size() != 0, 1);
            check("lsu_resp_lat", cyc, last_mresp_cyc + 1);
            if (lsu_q.size() != 0) begin
               r = lsu_q.pop_front();
               check("lsu_rdata", bus.lsu_rdata, r);
            end
         end
      end
   end

   initial begin
      int t0;
      int n0;
      bus.ifu_reqValid = 1'b0;
      bus.ifu_addr     = '0;
      bus.lsu_reqValid = 1'b0;
      bus.lsu_addr     = '0;
      bus.lsu_size     = '0;
      bus.lsu_wen      = 1'b0;
      bus.lsu_wdata    = '0;
      bus.lsu_wmask    = '0;

      repeat (3) @(negedge clock);
      check("rst_busy", bus.busy, 0);
      check("rst_mem_reqValid", bus.mem_reqValid, 0);
      check("rst_ifu_respValid", bus.ifu_respValid, 0);
      check("rst_lsu_respValid", bus.lsu_respValid, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_ifu_rdata", bus.ifu_rdata, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Fetch alone
      mem_lat = 1;
      mreq_cyc_q.delete();
      t0 = cyc;
      set_ifu(32'h8000_0000);
      @(negedge clock) clr_req();
      wait_idle();
      check("t1_mreq_cyc", mreq_cyc_q[0], t0 + 1);
      check("t1_iresp_cyc", last_iresp_cyc, t0 + 3);
      check("t1_rdata_held", bus.ifu_rdata, 32'h0000_0413);

      // Byte store
      mem_lat = 2;
      t0 = cyc;
      set_lsu(32'h0F00_0004, 2'd0, 1'b1, 32'h0000_00AB, 4'h1);
      @(negedge clock) clr_req();
      wait_idle();
      check("t2_lresp_cyc", last_lresp_cyc, t0 + 4);
      check("t2_mem_wen_held", bus.mem_wen, 1);

      // Tie after reset: IFU first, LSU one cycle after the fetch response
      mem_lat = 1;
      mreq_cyc_q.delete();
      t0 = cyc;
      set_ifu(32'h8000_0010);
      set_lsu(32'h2000_0040, 2'd2, 1'b0, 32'h0, 4'h0);
      @(negedge clock) clr_req();
      wait_idle();
      check("t3_ifu_mreq", mreq_cyc_q[0], t0 + 1);
      check("t3_lsu_mreq", mreq_cyc_q[1], last_iresp_cyc + 1);
      check("t3_lsu_mreq_abs", mreq_cyc_q[1], t0 + 4);

      // Fetch alone leaves last_grant on IFU, so the next tie goes to LSU
      set_ifu(32'h8000_0020);
      @(negedge clock) clr_req();
      wait_idle();
      mreq_cyc_q.delete();
      t0 = cyc;
      set_lsu(32'h2000_0080, 2'd1, 1'b1, 32'h0000_BEEF, 4'h3);
      set_ifu(32'h8000_0024);
      @(negedge clock) clr_req();
      wait_idle();
      check("t3b_lsu_mreq", mreq_cyc_q[0], t0 + 1);
      check("t3b_ifu_mreq", mreq_cyc_q[1], t0 + 4);

      // LSU request while a slow fetch is outstanding
      mem_lat = 5;
      mreq_cyc_q.delete();
      t0 = cyc;
      set_ifu(32'h8000_0100);
      @(negedge clock) clr_req();
      @(negedge clock);
      set_lsu(32'h3000_00F0, 2'd2, 1'b1, 32'hCAFE_F00D, 4'hF);
      @(negedge clock) clr_req();
      wait_idle();
      check("t4_ifu_mreq", mreq_cyc_q[0], t0 + 1);
      check("t4_lsu_mreq", mreq_cyc_q[1], t0 + 8);

      // Zero-wait memory, alternating requesters
      mem_lat = 0;
      for (int i = 0; i < 3; i++) begin
         mreq_cyc_q.delete();
         t0 = cyc;
         set_ifu(32'h8000_0200 + 32'(i * 4));
         @(negedge clock) clr_req();
         set_lsu(32'h4000_0000 + 32'(i * 8), 2'(i), 1'b0, 32'h0, 4'h0);
         @(negedge clock) clr_req();
         wait_idle();
         check("t5_first_mreq", mreq_cyc_q[0], t0 + 1);
         check("t5_spacing", mreq_cyc_q[1] - mreq_cyc_q[0], 2);
      end

      // Reset mid-transaction; the late memory response must be ignored
      mem_lat = 6;
      n0 = n_resp;
      set_ifu(32'h8000_0300);
      @(negedge clock) clr_req();
      @(negedge clock);
      reset = 1'b1;
      ifu_q.delete();
      mem_q.delete();
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      check("t6_busy", bus.busy, 0);
      check("t6_mem_reqValid", bus.mem_reqValid, 0);
      check("t6_mem_addr", bus.mem_addr, 0);
      check("t6_ifu_rdata", bus.ifu_rdata, 0);
      check("t6_lsu_rdata", bus.lsu_rdata, 0);
      check("t6_no_resp", n_resp, n0);

      // last_grant back at LSU after reset: tie goes to IFU
      mem_lat = 1;
      mreq_cyc_q.delete();
      t0 = cyc;
      set_ifu(32'h8000_0400);
      set_lsu(32'h5000_0010, 2'd2, 1'b0, 32'h0, 4'h0);
      @(negedge clock) clr_req();
      wait_idle();
      check("t6_tie_ifu_mreq", mreq_cyc_q[0], t0 + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1);
   end

endmodule
